// File: rtl/sc_bus_arbiter_pkg.sv
// Shared definitions for the two-master system bus arbiter.
// Master IDs, bus widths and the per-master request bundle.
package sc_bus_arbiter_pkg;

  typedef logic mid_t;

  localparam mid_t M_CPU = 1'b0;
  localparam mid_t M_LDR = 1'b1;

  localparam int BUS_W = 32;
  localparam int BE_W  = 4;

  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [BE_W-1:0]  be;
    logic             we;
  } bus_req_t;

  localparam bus_req_t BUS_IDLE = '0;

  function automatic mid_t other(mid_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/sc_bus_rd_tag_pipe.sv
// Read-response tag delay line: carries {valid,id} of each granted
// access across the fixed memory read latency.
module sc_bus_rd_tag_pipe
  import sc_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_valid_i,
  input  mid_t push_id_i,
  output logic pop_valid_o,
  output mid_t pop_id_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk  = clk_i ^ rst_i;
    assign pop_valid_o = push_valid_i;
    assign pop_id_o    = push_id_i;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] id_q, id_d;

    always_comb begin
      vld_d[0] = push_valid_i;
      id_d[0]  = push_id_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
        id_q  <= '0;
      end else begin
        vld_q <= vld_d;
        id_q  <= id_d;
      end
    end

    assign pop_valid_o = vld_q[DEPTH-1];
    assign pop_id_o    = id_q[DEPTH-1];
  end

endmodule

// File: rtl/sc_bus_arbiter.sv
// Round-robin two-master bus arbiter with bounded lock and
// read-response routing back to the issuing master.
module sc_bus_arbiter
  import sc_bus_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_lock_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  input  logic        m0_we_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  input  logic        m1_we_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        bus_be0_o,
  output logic        bus_be1_o,
  output logic        bus_be2_o,
  output logic        bus_be3_o,
  output logic        bus_we_o,
  input  logic [31:0] bus_rdata_i
);

  localparam int CW = $clog2(MAX_LOCK);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK - 1);

  logic [1:0] req, lock;
  bus_req_t   req_bus [2];
  bus_req_t   bus;

  assign req  = {m1_req_i, m0_req_i};
  assign lock = {m1_lock_i, m0_lock_i};

  assign req_bus[0] = '{m0_addr_i, m0_wdata_i, m0_be_i, m0_we_i};
  assign req_bus[1] = '{m1_addr_i, m1_wdata_i, m1_be_i, m1_we_i};

  mid_t          prio_q, prio_d;
  logic          own_vld_q, own_vld_d;
  mid_t          own_id_q, own_id_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic gnt_vld;
  mid_t gnt_id;
  logic own_ok;

  // Owner keeps the bus until the hold budget runs out with the other waiting
  assign own_ok = own_vld_q && req[own_id_q] &&
                  (lock_cnt_q < CNT_MAX || !req[other(own_id_q)]);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = M_CPU;
    if (!rst_i) begin
      if (own_ok) begin
        gnt_vld = 1'b1;
        gnt_id  = own_id_q;
      end else if (req == 2'b11) begin
        gnt_vld = 1'b1;
        gnt_id  = prio_q;
      end else if (req == 2'b01) begin
        gnt_vld = 1'b1;
        gnt_id  = M_CPU;
      end else if (req == 2'b10) begin
        gnt_vld = 1'b1;
        gnt_id  = M_LDR;
      end
    end
  end

  always_comb begin
    prio_d     = prio_q;
    own_vld_d  = 1'b0;
    own_id_d   = own_id_q;
    lock_cnt_d = '0;
    if (gnt_vld) begin
      prio_d = other(gnt_id);
      if (lock[gnt_id]) begin
        own_vld_d = 1'b1;
        own_id_d  = gnt_id;
        if (own_vld_q && own_id_q == gnt_id) begin
          lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q
                                               : lock_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q     <= M_CPU;
      own_vld_q  <= 1'b0;
      own_id_q   <= M_CPU;
      lock_cnt_q <= '0;
    end else begin
      prio_q     <= prio_d;
      own_vld_q  <= own_vld_d;
      own_id_q   <= own_id_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign m0_gnt_o = gnt_vld && gnt_id == M_CPU;
  assign m1_gnt_o = gnt_vld && gnt_id == M_LDR;

  assign bus         = gnt_vld ? req_bus[gnt_id] : BUS_IDLE;
  assign bus_addr_o  = bus.addr;
  assign bus_wdata_o = bus.wdata;
  assign bus_be0_o   = bus.be[0];
  assign bus_be1_o   = bus.be[1];
  assign bus_be2_o   = bus.be[2];
  assign bus_be3_o   = bus.be[3];
  assign bus_we_o    = bus.we;

  logic pop_valid;
  mid_t pop_id;
  logic rv;

  sc_bus_rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_tag_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_valid_i(gnt_vld && !bus.we),
    .push_id_i   (gnt_id),
    .pop_valid_o (pop_valid),
    .pop_id_o    (pop_id)
  );

  assign rv          = pop_valid && !rst_i;
  assign m0_rvalid_o = rv && pop_id == M_CPU;
  assign m1_rvalid_o = rv && pop_id == M_LDR;
  assign m0_rdata_o  = m0_rvalid_o ? bus_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? bus_rdata_i : '0;

endmodule

// File: tb/tb_sc_bus_arbiter.sv
// Bench for sc_bus_arbiter: four instances (read latency 0..3) share
// stimulus; directed vector table plus random traffic vs. a reference model.
module tb_sc_bus_arbiter;

  localparam int ML = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r [2];
  logic        lk [2];
  logic        w [2];
  logic [31:0] a [2];
  logic [31:0] d [2];
  logic [3:0]  b [2];
  logic [31:0] bus_rdata;

  logic        m0_gnt [4], m1_gnt [4], m0_rv [4], m1_rv [4];
  logic [31:0] m0_rd [4], m1_rd [4], bus_addr [4], bus_wdata [4];
  logic        be0 [4], be1 [4], be2 [4], be3 [4], bus_we [4];

  for (genvar L = 0; L < 4; L++) begin : g_dut
    sc_bus_arbiter #(
      .RD_LATENCY(L),
      .MAX_LOCK  (ML)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .m0_req_i   (r[0]),
      .m0_lock_i  (lk[0]),
      .m0_addr_i  (a[0]),
      .m0_wdata_i (d[0]),
      .m0_be_i    (b[0]),
      .m0_we_i    (w[0]),
      .m0_gnt_o   (m0_gnt[L]),
      .m0_rvalid_o(m0_rv[L]),
      .m0_rdata_o (m0_rd[L]),
      .m1_req_i   (r[1]),
      .m1_lock_i  (lk[1]),
      .m1_addr_i  (a[1]),
      .m1_wdata_i (d[1]),
      .m1_be_i    (b[1]),
      .m1_we_i    (w[1]),
      .m1_gnt_o   (m1_gnt[L]),
      .m1_rvalid_o(m1_rv[L]),
      .m1_rdata_o (m1_rd[L]),
      .bus_addr_o (bus_addr[L]),
      .bus_wdata_o(bus_wdata[L]),
      .bus_be0_o  (be0[L]),
      .bus_be1_o  (be1[L]),
      .bus_be2_o  (be2[L]),
      .bus_be3_o  (be3[L]),
      .bus_we_o   (bus_we[L]),
      .bus_rdata_i(bus_rdata)
    );
  end

  int total = 0;
  int bad   = 0;

  // Reference model state: grant history expressed as streaks
  int k;
  int hold_id;
  int streak;
  int pref;
  int exp_g;
  int due [4][64];

  typedef struct {
    logic rst, r0, l0, w0, r1, l1, w1;
    logic g0, g1, v0, v1;
  } vec_t;

  vec_t tbl [26];

  function automatic logic [31:0] rd_val(int c);
    return 32'hC0DE_0000 ^ (32'(c) * 32'h0001_0103);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, k);
    end
  endtask

  task automatic model_check();
    int g;
    int e;
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    logic        ewe;
    g = -1;
    if (!rst) begin
      if (hold_id >= 0 && r[hold_id] && (!r[1-hold_id] || streak < ML))
        g = hold_id;
      else if (r[0] && r[1]) g = pref;
      else if (r[0]) g = 0;
      else if (r[1]) g = 1;
    end
    ea = '0; ed = '0; eb = '0; ewe = 1'b0;
    if (g >= 0) begin
      ea = a[g]; ed = d[g]; eb = b[g]; ewe = w[g];
      if (!w[g])
        for (int L = 0; L < 4; L++) due[L][(k + L) % 64] = g;
    end
    for (int L = 0; L < 4; L++) begin
      e = rst ? -1 : due[L][k % 64];
      chk($sformatf("L%0d gnt0", L), 32'(m0_gnt[L]), 32'(g == 0));
      chk($sformatf("L%0d gnt1", L), 32'(m1_gnt[L]), 32'(g == 1));
      chk($sformatf("L%0d addr", L), bus_addr[L], ea);
      chk($sformatf("L%0d wdata", L), bus_wdata[L], ed);
      chk($sformatf("L%0d be", L),
          32'({be3[L], be2[L], be1[L], be0[L]}), 32'(eb));
      chk($sformatf("L%0d we", L), 32'(bus_we[L]), 32'(ewe));
      chk($sformatf("L%0d rv0", L), 32'(m0_rv[L]), 32'(e == 0));
      chk($sformatf("L%0d rv1", L), 32'(m1_rv[L]), 32'(e == 1));
      chk($sformatf("L%0d rd0", L), m0_rd[L], (e == 0) ? rd_val(k) : 32'h0);
      chk($sformatf("L%0d rd1", L), m1_rd[L], (e == 1) ? rd_val(k) : 32'h0);
    end
    exp_g = g;
  endtask

  task automatic model_update();
    for (int L = 0; L < 4; L++) due[L][k % 64] = -1;
    if (rst) begin
      for (int L = 0; L < 4; L++)
        for (int i = 0; i < 64; i++) due[L][i] = -1;
      hold_id = -1; streak = 0; pref = 0;
    end else if (exp_g >= 0) begin
      pref = 1 - exp_g;
      if (lk[exp_g]) begin
        if (hold_id == exp_g) streak++;
        else begin
          hold_id = exp_g;
          streak  = 1;
        end
      end else begin
        hold_id = -1; streak = 0;
      end
    end else begin
      hold_id = -1; streak = 0;
    end
    k++;
  endtask

  task automatic table_check(int i);
    chk($sformatf("tbl%0d gnt0", i), 32'(m0_gnt[1]), 32'(tbl[i].g0));
    chk($sformatf("tbl%0d gnt1", i), 32'(m1_gnt[1]), 32'(tbl[i].g1));
    chk($sformatf("tbl%0d rv0", i), 32'(m0_rv[1]), 32'(tbl[i].v0));
    chk($sformatf("tbl%0d rv1", i), 32'(m1_rv[1]), 32'(tbl[i].v1));
  endtask

  task automatic step(int ti);
    bus_rdata = rd_val(k);
    @(negedge clk);
    model_check();
    if (ti >= 0) table_check(ti);
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic vec_t mk(logic rs, logic r0, logic l0, logic w0,
                              logic r1, logic l1, logic w1,
                              logic g0, logic g1, logic v0, logic v1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.l0 = l0; v.w0 = w0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  bit pend [2];

  initial begin
    k = 0; hold_id = -1; streak = 0; pref = 0; exp_g = -1;
    for (int L = 0; L < 4; L++)
      for (int i = 0; i < 64; i++) due[L][i] = -1;

    //            rst r0 l0 w0 r1 l1 w1  g0 g1 v0 v1
    tbl[0]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[9]  = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[11] = mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0);
    tbl[12] = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1);
    tbl[13] = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    tbl[15] = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1);
    tbl[16] = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[17] = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[18] = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0);
    tbl[19] = mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    tbl[22] = mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    rst = 1'b1;
    bus_rdata = '0;
    for (int m = 0; m < 2; m++) begin
      r[m] = 1'b0; lk[m] = 1'b0; w[m] = 1'b0;
      a[m] = '0; d[m] = '0; b[m] = '0;
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 26; i++) begin
      rst   = tbl[i].rst;
      r[0]  = tbl[i].r0; lk[0] = tbl[i].l0; w[0] = tbl[i].w0;
      r[1]  = tbl[i].r1; lk[1] = tbl[i].l1; w[1] = tbl[i].w1;
      a[0]  = 32'h10;
      d[0]  = 32'h0;
      b[0]  = 4'hF;
      a[1]  = tbl[i].w1 ? 32'h100 : 32'h20;
      d[1]  = 32'hDEAD_BEEF;
      b[1]  = tbl[i].w1 ? 4'b0011 : 4'hF;
      step(i);
    end

    for (int m = 0; m < 2; m++) begin
      r[m] = 1'b0; lk[m] = 1'b0; pend[m] = 1'b0;
    end

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          if ($urandom_range(0, 3) != 0) begin
            r[m]    = 1'b1;
            pend[m] = 1'b1;
            a[m]    = $urandom;
            d[m]    = $urandom;
            b[m]    = 4'($urandom_range(1, 15));
            w[m]    = 1'($urandom_range(0, 1));
            lk[m]   = 1'($urandom_range(0, 1));
          end else begin
            r[m]  = 1'b0;
            lk[m] = 1'b0;
          end
        end
      end
      step(-1);
      for (int m = 0; m < 2; m++)
        if (exp_g == m) pend[m] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
